// File: rtl/dual_ram_bist_master.sv
// -----------------------------------------------------------------------------
// dual_ram_bist_master
//
// Self-test initiator for a dual-port synchronous RAM. Port A is used only as
// the writer and port B only as the reader. A run consists of two passes.
// Each pass writes every address through port A with the pattern
//   exp(a,p) = a[DATA_W-1:0] ^ {DATA_W{p}}
// and then reads every address back through port B, comparing each word with
// the expected value. The block reports the mismatch count, a pass flag and
// the address and pass index of the first mismatch.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             level, accepted only in IDLE
//   we_a, oe_a        port A write enable / output enable (oe_a tied 0)
//   addr_a, wdata_a   port A address / write data
//   we_b, oe_b        port B write enable (tied 0) / output enable
//   addr_b, wdata_b   port B address / write data (tied 0)
//   rdata_b           port B read data, registered by the RAM (1-cycle latency)
//   busy              high in every state except IDLE
//   done              one-cycle pulse in the DONE state
//   pass              last run finished with zero mismatches
//   err_count         mismatches in the last run
//   first_fail_addr   address of the first mismatch of the last run
//   first_fail_pass   pass index of the first mismatch of the last run
// -----------------------------------------------------------------------------
module dual_ram_bist_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              we_a,
  output logic              oe_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] wdata_a,
  output logic              we_b,
  output logic              oe_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] wdata_b,
  input  logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_pass
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;       // shared write/read address counter
  logic              pidx;      // current pass index
  logic              valid_d;   // a read was issued last cycle
  logic [DATA_W-1:0] exp_d;     // expected data for that read
  logic [ADDR_W-1:0] addr_d;    // address of that read
  logic              pass_r;
  logic              mismatch;
  logic [ADDR_W+1:0] err_next;
  logic              cnt_max;

  function automatic logic [DATA_W-1:0] exp_pat(input logic [ADDR_W-1:0] a,
                                                input logic              p);
    return a[DATA_W-1:0] ^ {DATA_W{p}};
  endfunction

  assign cnt_max  = &cnt;
  assign mismatch = valid_d && (rdata_b != exp_d);
  assign err_next = err_count + (ADDR_W+2)'(mismatch);

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt = state;
    we_a      = 1'b0;
    addr_a    = '0;
    wdata_a   = '0;
    oe_b      = 1'b0;
    addr_b    = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        we_a    = 1'b1;
        addr_a  = cnt;
        wdata_a = exp_pat(cnt, pidx);
        if (cnt_max) state_nxt = READ;
      end
      READ: begin
        oe_b   = 1'b1;
        addr_b = cnt;
        if (cnt_max) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Counter has already wrapped; keep the last address on the port
        // while the final registered read is compared.
        oe_b      = 1'b1;
        addr_b    = '1;
        state_nxt = pidx ? DONE : WRITE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign oe_a    = 1'b0;
  assign we_b    = 1'b0;
  assign wdata_b = '0;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign pass    = pass_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      pidx            <= 1'b0;
      valid_d         <= 1'b0;
      exp_d           <= '0;
      addr_d          <= '0;
      pass_r          <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_pass <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= state_nxt;

      // Align expected data/address with the RAM's one-cycle read latency.
      valid_d <= (state == READ);
      exp_d   <= exp_pat(cnt, pidx);
      addr_d  <= cnt;

      unique case (state)
        IDLE: begin
          if (start) begin
            cnt             <= '0;
            pidx            <= 1'b0;
            pass_r          <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_pass <= 1'b0;
          end
        end
        WRITE, READ: cnt <= cnt + 1'b1;  // wraps to 0 on the terminal count
        DRAIN: begin
          if (!pidx) pidx <= 1'b1;
          // The last comparison lands here, so fold it in before DONE.
          else       pass_r <= (err_next == '0);
        end
        default: ;
      endcase

      // Mismatches occur only in READ/DRAIN, never alongside the IDLE clear.
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) begin
          first_fail_addr <= addr_d;
          first_fail_pass <= pidx;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_ram_bist_master.sv
// -----------------------------------------------------------------------------
// tb_dual_ram_bist_master
//
// Directed bench for dual_ram_bist_master with a behavioural 16x2 dual-port
// RAM that can be switched between fault-free, address-5 bit-0 stuck-at-1,
// and a read port tied to zero. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_dual_ram_bist_master;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              we_a, oe_a, we_b, oe_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b, rdata_b;
  logic              busy, done, pass;
  logic [ADDR_W+1:0] err_count;
  logic [ADDR_W-1:0] first_fail_addr;
  logic              first_fail_pass;

  int n_pass  = 0;
  int n_total = 0;

  // RAM model: 0 = good, 1 = addr 5 bit 0 stuck at 1, 2 = read port stuck 0.
  int                fault_mode = 0;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rreg;

  // Per-run observations.
  int lat, busy_cycles, done_cnt, wr_count, wr_err;

  always #5 clk = ~clk;

  dual_ram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .we_a(we_a), .oe_a(oe_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .we_b(we_b), .oe_b(oe_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .first_fail_pass(first_fail_pass)
  );

  always @(posedge clk) begin
    if (we_a) begin
      if (fault_mode == 1 && addr_a == 4'd5) mem[addr_a] <= wdata_a | 2'b01;
      else                                   mem[addr_a] <= wdata_a;
    end
    if (oe_b) rreg <= mem[addr_b];
  end
  assign rdata_b = (fault_mode == 2) ? '0 : rreg;

  // Pulse (or hold) start and watch 80 cycles; hold_start drops start only
  // once done has been observed.
  task automatic run_test(input bit hold_start);
    bit seen;
    logic [1:0] exp_w;
    int a, pp;
    seen = 0; lat = 0; busy_cycles = 0; done_cnt = 0; wr_count = 0; wr_err = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (!hold_start) start = 1'b0;
      if (busy) busy_cycles++;
      if (we_a) begin
        a  = wr_count % 16;
        pp = wr_count / 16;
        exp_w = pp[0] ? 2'(3 - (a % 4)) : 2'(a % 4);
        if (addr_a != 4'(a) || wdata_a !== exp_w) wr_err++;
        wr_count++;
      end
      if (done) begin
        done_cnt++;
        if (!seen) lat = i + 1;
        seen = 1;
        start = 1'b0;
      end
    end
    n_total++;
    if (!seen) $display("FAIL run_timeout: no done within 80 cycles");
    else       n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    #3;
    n_total++;
    if ({busy, done, pass} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, pass});
    else n_pass++;
    n_total++;
    if ({we_a, oe_b, addr_a, addr_b, wdata_a} !== '0)
      $display("FAIL reset_ports: got %h want 0", {we_a, oe_b, addr_a, addr_b, wdata_a});
    else n_pass++;
    n_total++;
    if ({err_count, first_fail_addr, first_fail_pass} !== '0)
      $display("FAIL reset_results: got %h want 0", {err_count, first_fail_addr, first_fail_pass});
    else n_pass++;
    n_total++;
    if ({oe_a, we_b, wdata_b} !== '0) $display("FAIL tied_ports: got %b want 0", {oe_a, we_b, wdata_b});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fault_free();
    fault_mode = 0;
    run_test(0);
    n_total++;
    if (lat != 67) $display("FAIL ff_latency: got %0d want 67", lat); else n_pass++;
    n_total++;
    if (busy_cycles != 67) $display("FAIL ff_busy: got %0d want 67", busy_cycles); else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL ff_done_pulses: got %0d want 1", done_cnt); else n_pass++;
    n_total++;
    if (pass !== 1'b1 || err_count !== 6'd0)
      $display("FAIL ff_result: got pass=%b err=%0d want pass=1 err=0", pass, err_count);
    else n_pass++;
  endtask

  task automatic test_write_trace();
    n_total++;
    if (wr_count != 32) $display("FAIL write_count: got %0d want 32", wr_count); else n_pass++;
    n_total++;
    if (wr_err != 0) $display("FAIL write_trace: got %0d bad writes want 0", wr_err); else n_pass++;
  endtask

  task automatic test_stuck_at();
    fault_mode = 1;
    run_test(0);
    n_total++;
    if (err_count !== 6'd1) $display("FAIL stuck_err: got %0d want 1", err_count); else n_pass++;
    n_total++;
    if (first_fail_addr !== 4'd5 || first_fail_pass !== 1'b1)
      $display("FAIL stuck_first: got addr=%0d pass=%b want addr=5 pass=1", first_fail_addr, first_fail_pass);
    else n_pass++;
    n_total++;
    if (pass !== 1'b0) $display("FAIL stuck_pass: got %b want 0", pass); else n_pass++;
  endtask

  // All-zero reads match only where exp is 0: a%4==0 in pass 0, a%4==3 in
  // pass 1, leaving 12 mismatches per pass.
  task automatic test_broken_read();
    fault_mode = 2;
    run_test(0);
    n_total++;
    if (err_count !== 6'd24) $display("FAIL broken_err: got %0d want 24", err_count); else n_pass++;
    n_total++;
    if (first_fail_addr !== 4'd1 || first_fail_pass !== 1'b0)
      $display("FAIL broken_first: got addr=%0d pass=%b want addr=1 pass=0", first_fail_addr, first_fail_pass);
    else n_pass++;
    n_total++;
    if (pass !== 1'b0) $display("FAIL broken_pass: got %b want 0", pass); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fault_mode = 0;
    run_test(1);
    n_total++;
    if (done_cnt != 1 || busy_cycles != 67)
      $display("FAIL hold_start: got done=%0d busy=%0d want done=1 busy=67", done_cnt, busy_cycles);
    else n_pass++;
    n_total++;
    if (err_count !== 6'd0 || first_fail_addr !== 4'd0 || pass !== 1'b1)
      $display("FAIL rearm_clear: got err=%0d ffa=%0d pass=%b want 0 0 1", err_count, first_fail_addr, pass);
    else n_pass++;
    run_test(0);
    n_total++;
    if (lat != 67 || pass !== 1'b1 || err_count !== 6'd0)
      $display("FAIL rearm_repeat: got lat=%0d pass=%b err=%0d want 67 1 0", lat, pass, err_count);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    bit found;
    int dn;
    found = 0; dn = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (oe_b && addr_b == 4'd7) found = 1;
    end
    n_total++;
    if (!found) $display("FAIL midrun_reach: addr_b=7 read not seen within 40 cycles");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy, done, pass, we_a, oe_b, addr_a, addr_b, wdata_a, err_count, first_fail_addr, first_fail_pass} !== '0)
      $display("FAIL midrun_reset: got busy=%b oe_b=%b addr_b=%0d pass=%b want all 0", busy, oe_b, addr_b, pass);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    n_total++;
    if (dn != 0) $display("FAIL midrun_no_done: got %0d pulses want 0", dn); else n_pass++;
    run_test(0);
    n_total++;
    if (lat != 67 || pass !== 1'b1) $display("FAIL midrun_restart: got lat=%0d pass=%b want 67 1", lat, pass);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_write_trace();
    test_stuck_at();
    test_broken_read();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
